// File: rtl/cpu_pkg.sv
// Shared CPU constants and helpers.
// Used by the pipeline stage registers and the hazard unit.
package cpu_pkg;

    localparam int          TNEW_W    = 4;
    localparam int          PAYLOAD_W = 192;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] EXC_PC    = 32'h0000_4180;

    // Tnew counts down toward 0 and sticks there.
    function automatic logic [TNEW_W-1:0] sat_dec(
        input logic [TNEW_W-1:0] t
    );
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat carrying PC, instr, GRF write, Tnew and payload.
// master drives the beat, slave returns ready.
interface pipe_stage_reg_if #(
    parameter int PAYLOAD_W = cpu_pkg::PAYLOAD_W,
    parameter int TNEW_W    = cpu_pkg::TNEW_W
);
    logic                 valid;
    logic                 ready;
    logic [31:0]          pc;
    logic [31:0]          instr;
    logic                 grf_write;
    logic [TNEW_W-1:0]    tnew;
    logic [PAYLOAD_W-1:0] payload;

    modport master (
        output valid, pc, instr, grf_write, tnew, payload,
        input  ready
    );

    modport slave (
        input  valid, pc, instr, grf_write, tnew, payload,
        output ready
    );
endinterface

// File: rtl/stage_entry.sv
// One register slice of a pipeline stage with valid bit.
// clr_i forces the exception bubble, load_i captures, kill_i drops valid.
module stage_entry #(
    parameter int          PAYLOAD_W = cpu_pkg::PAYLOAD_W,
    parameter int          TNEW_W    = cpu_pkg::TNEW_W,
    parameter logic [31:0] RST_PC    = cpu_pkg::RESET_PC,
    parameter logic [31:0] EXC_PC    = cpu_pkg::EXC_PC
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic                 kill_i,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          instr_i,
    input  logic                 grf_write_i,
    input  logic [TNEW_W-1:0]    tnew_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output logic                 valid_o,
    output logic [31:0]          pc_o,
    output logic [31:0]          instr_o,
    output logic                 grf_write_o,
    output logic [TNEW_W-1:0]    tnew_o,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic                 valid_q, valid_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          instr_q, instr_d;
    logic                 gw_q, gw_d;
    logic [TNEW_W-1:0]    tnew_q, tnew_d;
    logic [PAYLOAD_W-1:0] pl_q, pl_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        gw_d    = gw_q;
        tnew_d  = tnew_q;
        pl_d    = pl_q;
        if (clr_i) begin
            valid_d = 1'b0;
            pc_d    = EXC_PC;
            instr_d = '0;
            gw_d    = 1'b0;
            tnew_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
            gw_d    = grf_write_i;
            tnew_d  = tnew_i;
            pl_d    = payload_i;
        end else if (kill_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= RST_PC;
            instr_q <= '0;
            gw_q    <= 1'b0;
            tnew_q  <= '0;
            pl_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            gw_q    <= gw_d;
            tnew_q  <= tnew_d;
            pl_q    <= pl_d;
        end
    end

    assign valid_o     = valid_q;
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign grf_write_o = gw_q;
    assign tnew_o      = tnew_q;
    assign payload_o   = pl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: main entry plus a skid entry.
// in_ready depends only on skid state, so stalls stay local.
module pipe_stage_reg #(
    parameter int          PAYLOAD_W = cpu_pkg::PAYLOAD_W,
    parameter int          TNEW_W    = cpu_pkg::TNEW_W,
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] EXC_PC    = cpu_pkg::EXC_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    pipe_stage_reg_if.slave  in_if,
    pipe_stage_reg_if.master out_if
);

    logic                 main_v, skid_v;
    logic [31:0]          main_pc, skid_pc;
    logic [31:0]          main_instr, skid_instr;
    logic                 main_gw, skid_gw;
    logic [TNEW_W-1:0]    main_tnew, skid_tnew;
    logic [PAYLOAD_W-1:0] main_pl, skid_pl;

    logic                 accept, fire, main_free;
    logic                 main_load, main_kill;
    logic                 skid_load, skid_kill;
    logic [TNEW_W-1:0]    tnew_cap;
    logic [31:0]          mpc_in, minstr_in;
    logic                 mgw_in;
    logic [TNEW_W-1:0]    mtnew_in;
    logic [PAYLOAD_W-1:0] mpl_in;

    assign in_if.ready = ~skid_v;
    assign accept      = in_if.valid & ~skid_v;
    assign fire        = main_v & out_if.ready;
    assign main_free   = ~main_v | fire;

    assign tnew_cap = (in_if.tnew == '0) ? '0
                    : in_if.tnew - TNEW_W'(1);

    // Skid drains into main first so ordering stays FIFO.
    assign main_load = main_free & (skid_v | accept);
    assign main_kill = main_free & ~skid_v & ~accept;
    assign skid_load = ~main_free & accept;
    assign skid_kill = main_free & skid_v;

    assign mpc_in    = skid_v ? skid_pc    : in_if.pc;
    assign minstr_in = skid_v ? skid_instr : in_if.instr;
    assign mgw_in    = skid_v ? skid_gw    : in_if.grf_write;
    assign mtnew_in  = skid_v ? skid_tnew  : tnew_cap;
    assign mpl_in    = skid_v ? skid_pl    : in_if.payload;

    stage_entry #(
        .PAYLOAD_W (PAYLOAD_W),
        .TNEW_W    (TNEW_W),
        .RST_PC    (RESET_PC),
        .EXC_PC    (EXC_PC)
    ) u_main (
        .clk_i       (clk),
        .rst_ni      (reset),
        .clr_i       (req),
        .load_i      (main_load),
        .kill_i      (main_kill),
        .pc_i        (mpc_in),
        .instr_i     (minstr_in),
        .grf_write_i (mgw_in),
        .tnew_i      (mtnew_in),
        .payload_i   (mpl_in),
        .valid_o     (main_v),
        .pc_o        (main_pc),
        .instr_o     (main_instr),
        .grf_write_o (main_gw),
        .tnew_o      (main_tnew),
        .payload_o   (main_pl)
    );

    stage_entry #(
        .PAYLOAD_W (PAYLOAD_W),
        .TNEW_W    (TNEW_W),
        .RST_PC    (RESET_PC),
        .EXC_PC    (EXC_PC)
    ) u_skid (
        .clk_i       (clk),
        .rst_ni      (reset),
        .clr_i       (req),
        .load_i      (skid_load),
        .kill_i      (skid_kill),
        .pc_i        (in_if.pc),
        .instr_i     (in_if.instr),
        .grf_write_i (in_if.grf_write),
        .tnew_i      (tnew_cap),
        .payload_i   (in_if.payload),
        .valid_o     (skid_v),
        .pc_o        (skid_pc),
        .instr_o     (skid_instr),
        .grf_write_o (skid_gw),
        .tnew_o      (skid_tnew),
        .payload_o   (skid_pl)
    );

    assign out_if.valid     = main_v;
    assign out_if.pc        = main_pc;
    assign out_if.instr     = main_instr;
    assign out_if.grf_write = main_gw & main_v;
    assign out_if.tnew      = main_v ? main_tnew : '0;
    assign out_if.payload   = main_pl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a random
// valid/ready run checked against an in-order scoreboard.
module tb_pipe_stage_reg;

    localparam int PW = 192;
    localparam int TW = 4;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic          gw;
        logic [TW-1:0] tnew;
        logic [PW-1:0] pl;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic req   = 1'b0;

    int errors    = 0;
    int checks    = 0;
    int delivered = 0;

    beat_t sb[$];
    beat_t mb, me;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.PAYLOAD_W(PW), .TNEW_W(TW)) up ();
    pipe_stage_reg_if #(.PAYLOAD_W(PW), .TNEW_W(TW)) dn ();

    pipe_stage_reg #(
        .PAYLOAD_W (PW),
        .TNEW_W    (TW),
        .RESET_PC  (32'h0000_3000),
        .EXC_PC    (32'h0000_4180)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .req    (req),
        .in_if  (up),
        .out_if (dn)
    );

    function automatic logic [TW-1:0] exp_tnew(input logic [TW-1:0] t);
        if (t == '0) return '0;
        return t - TW'(1);
    endfunction

    task automatic put(input logic v, input logic [31:0] pc,
                       input logic [31:0] instr, input logic gw,
                       input logic [TW-1:0] tn, input logic ordy);
        up.valid     = v;
        up.pc        = pc;
        up.instr     = instr;
        up.grf_write = gw;
        up.tnew      = tn;
        up.payload   = {$urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom()};
        dn.ready     = ordy;
    endtask

    // Scoreboard monitor: both edges' handshakes are stable at negedge.
    always @(negedge clk) begin
        if (!rst_n || req) begin
            sb.delete();
        end else begin
            if (dn.valid && dn.ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got pc=%h, no beat expected",
                             dn.pc);
                end else begin
                    me = sb.pop_front();
                    delivered++;
                    if (dn.pc !== me.pc || dn.instr !== me.instr ||
                        dn.grf_write !== me.gw || dn.tnew !== me.tnew ||
                        dn.payload !== me.pl) begin
                        errors++;
                        $display("FAIL sb_beat: got pc=%h instr=%h gw=%b tnew=%h, want pc=%h instr=%h gw=%b tnew=%h",
                                 dn.pc, dn.instr, dn.grf_write, dn.tnew,
                                 me.pc, me.instr, me.gw, me.tnew);
                    end
                end
            end
            if (up.valid && up.ready) begin
                mb.pc    = up.pc;
                mb.instr = up.instr;
                mb.gw    = up.grf_write;
                mb.tnew  = exp_tnew(up.tnew);
                mb.pl    = up.payload;
                sb.push_back(mb);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        put(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dn.valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", dn.valid);
        end
        checks++;
        if (dn.pc !== 32'h3000) begin
            errors++; $display("FAIL reset_pc: got %h want 3000", dn.pc);
        end
        checks++;
        if (up.ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", up.ready);
        end
        checks++;
        if (dn.grf_write !== 1'b0) begin
            errors++; $display("FAIL reset_gw: got %b want 0", dn.grf_write);
        end
        checks++;
        if (dn.tnew !== 4'd0 || dn.instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_tnew_instr: got %h/%h want 0/0",
                     dn.tnew, dn.instr);
        end
    endtask

    task automatic test_single();
        @(posedge clk);
        #1 put(1'b1, 32'h3004, 32'h3c01_1234, 1'b1, 4'd2, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (dn.valid !== 1'b1 || dn.pc !== 32'h3004 ||
            dn.instr !== 32'h3c01_1234) begin
            errors++;
            $display("FAIL single_beat: got v=%b pc=%h instr=%h want 1/3004/3c011234",
                     dn.valid, dn.pc, dn.instr);
        end
        checks++;
        if (dn.tnew !== 4'd1 || dn.grf_write !== 1'b1) begin
            errors++;
            $display("FAIL single_tnew2: got tnew=%h gw=%b want 1/1",
                     dn.tnew, dn.grf_write);
        end
        put(1'b1, 32'h3008, 32'h0, 1'b0, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (dn.pc !== 32'h3008 || dn.tnew !== 4'd0) begin
            errors++;
            $display("FAIL single_tnew0: got pc=%h tnew=%h want 3008/0",
                     dn.pc, dn.tnew);
        end
        put(1'b1, 32'h300c, 32'h1, 1'b1, 4'd15, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (dn.tnew !== 4'd14) begin
            errors++; $display("FAIL single_tnew15: got %h want e", dn.tnew);
        end
        put(1'b0, 32'h0, 32'h0, 1'b1, 4'd3, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (dn.valid !== 1'b0 || dn.grf_write !== 1'b0 || dn.tnew !== 4'd0) begin
            errors++;
            $display("FAIL idle_gating: got v=%b gw=%b tnew=%h want 0/0/0",
                     dn.valid, dn.grf_write, dn.tnew);
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        int acc = 0;
        int d0 = delivered;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1 put(1'b1, 32'h3000 + 32'(4 * k), 32'h1000_0000 | 32'(k),
                   1'b1, TW'(k), c == 0);
            @(negedge clk);
            if (up.valid && up.ready) begin
                acc++; k++;
            end
        end
        checks++;
        if (acc != 2 || up.ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_fill: got accepted=%0d in_ready=%b want 2/0",
                     acc, up.ready);
        end
        checks++;
        if (dn.valid !== 1'b1 || dn.pc !== 32'h3000) begin
            errors++;
            $display("FAIL bp_hold: got v=%b pc=%h want 1/3000",
                     dn.valid, dn.pc);
        end
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(posedge clk);
            #1 put(1'b1, 32'h3000 + 32'(4 * k), 32'h1000_0000 | 32'(k),
                   1'b1, TW'(k), 1'b1);
            @(negedge clk);
            if (up.valid && up.ready) k++;
        end
        @(posedge clk);
        #1 put(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1);
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (delivered - d0 != 8 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got delivered=%0d pending=%0d want 8/0",
                     delivered - d0, sb.size());
        end
    endtask

    task automatic test_flush();
        int acc = 0;
        for (int c = 0; c < 10 && acc < 2; c++) begin
            @(posedge clk);
            #1 put(1'b1, 32'h5000 + 32'(4 * acc), 32'hdead_0000,
                   1'b1, 4'd3, 1'b0);
            @(negedge clk);
            if (up.valid && up.ready) acc++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (up.ready !== 1'b0 || dn.valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got in_ready=%b v=%b want 0/1",
                     up.ready, dn.valid);
        end
        req = 1'b1;
        put(1'b1, 32'h6000, 32'hbeef_0000, 1'b1, 4'd2, 1'b0);
        @(posedge clk);
        #1 req = 1'b0;
        put(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (dn.valid !== 1'b0 || dn.pc !== 32'h4180 || dn.instr !== 32'h0) begin
            errors++;
            $display("FAIL flush_out: got v=%b pc=%h instr=%h want 0/4180/0",
                     dn.valid, dn.pc, dn.instr);
        end
        checks++;
        if (dn.grf_write !== 1'b0 || up.ready !== 1'b1 || dn.tnew !== 4'd0) begin
            errors++;
            $display("FAIL flush_ctl: got gw=%b in_ready=%b tnew=%h want 0/1/0",
                     dn.grf_write, up.ready, dn.tnew);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dn.valid !== 1'b0 || dn.pc !== 32'h4180) begin
            errors++;
            $display("FAIL flush_drop: got v=%b pc=%h want 0/4180",
                     dn.valid, dn.pc);
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1 put(1'b1, 32'h7000 + 32'(4 * c), 32'h0, 1'b1, 4'd5, 1'b0);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (dn.valid !== 1'b0 || dn.pc !== 32'h3000 || up.ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_out: got v=%b pc=%h in_ready=%b want 0/3000/1",
                     dn.valid, dn.pc, up.ready);
        end
        checks++;
        if (dn.grf_write !== 1'b0 || dn.tnew !== 4'd0 || dn.instr !== 32'h0) begin
            errors++;
            $display("FAIL areset_fields: got gw=%b tnew=%h instr=%h want 0/0/0",
                     dn.grf_write, dn.tnew, dn.instr);
        end
        put(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dn.valid !== 1'b0 || dn.pc !== 32'h3000) begin
            errors++;
            $display("FAIL areset_release: got v=%b pc=%h want 0/3000",
                     dn.valid, dn.pc);
        end
    endtask

    task automatic test_random();
        int d0 = delivered;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1 put(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                   1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)),
                   $urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1 put(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1);
        for (int c = 0; c < 10 && sb.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || delivered - d0 < 2000) begin
            errors++;
            $display("FAIL random_drain: got pending=%0d delivered=%0d want 0/>=2000",
                     sb.size(), delivered - d0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
